// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder.
package dmem_pkg;

    // Top address bit selects between RAM and the MMIO window.
    typedef enum logic {
        RegionRam  = 1'b0,
        RegionMmio = 1'b1
    } region_e;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    // MMIO word offsets (daddr[4:2]).
    localparam logic [2:0] CONS_TX     = 3'd0;
    localparam logic [2:0] CONS_STATUS = 3'd1;
    localparam logic [2:0] CYCLE       = 3'd2;

    // CONS_STATUS field positions.
    localparam int unsigned OCC_LSB   = 0;
    localparam int unsigned FULL_BIT  = 8;
    localparam int unsigned EMPTY_BIT = 9;
    localparam int unsigned DROP_LSB  = 16;

    // Assemble the CONS_STATUS word; unlisted bits read 0.
    function automatic logic [31:0] status_word(input logic [4:0] occ,
                                                input logic       full,
                                                input logic       empty,
                                                input logic [7:0] drop);
        logic [31:0] w;
        w                 = '0;
        w[OCC_LSB +: 5]   = occ;
        w[FULL_BIT]       = full;
        w[EMPTY_BIT]      = empty;
        w[DROP_LSB +: 8]  = drop;
        return w;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Byte FIFO feeding the console sink over a valid/ready port.
module console_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       pop_valid,
    input  logic       pop_ready,
    output logic [7:0] pop_data,
    output logic [4:0] occupancy,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [4:0]  DEPTH_L = 5'(FIFO_DEPTH);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [4:0]       count_q, count_d;
    logic             pop, push_ok;

    assign full      = (count_q == DEPTH_L);
    assign empty     = (count_q == 5'd0);
    assign occupancy = count_q;
    assign pop_valid = !empty;
    assign pop       = pop_valid && pop_ready;
    // A push at full still fits when the head leaves in the same cycle.
    assign push_ok   = push && !reset && (!full || pop);
    // Empty FIFO presents 0 rather than stale storage.
    assign pop_data  = empty ? 8'h00 : mem[rd_ptr_q];

    // Occupancy next-state: simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM plus MMIO console FIFO and cycle counter.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic [7:0]  cons_data,
    output logic        cons_valid,
    input  logic        cons_ready
);

    logic [31:0]           ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_idx;
    region_e               region;
    logic [2:0]            mmio_off;

    logic [31:0] cycle_q;
    logic [7:0]  drop_q;
    logic        push, cycle_load, drop_evt;
    logic [4:0]  occupancy;
    logic        full, empty;

    // Aliased high address bits and byte offset do not take part in decode.
    logic unused_addr;
    assign unused_addr = ^{daddr[30:ADDR_WIDTH+2], daddr[1:0]};

    assign ram_idx  = daddr[ADDR_WIDTH+1:2];
    assign region   = region_e'(daddr[31]);
    assign mmio_off = daddr[4:2];

    assign push       = (region == RegionMmio) && (mmio_off == CONS_TX) && dwe[0] && !reset;
    assign cycle_load = (region == RegionMmio) && (mmio_off == CYCLE) && (dwe == 4'b1111);
    // Rejected push: full and the head is not leaving this cycle.
    assign drop_evt   = push && full && !(cons_valid && cons_ready);

    console_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (dwdata[7:0]),
        .pop_valid (cons_valid),
        .pop_ready (cons_ready),
        .pop_data  (cons_data),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    // Byte-lane RAM writes; reset blocks any write in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset && region == RegionRam) begin
            for (int i = 0; i < 4; i++) begin
                if (dwe[i]) ram[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
            end
        end
    end

    // Free-running cycle counter; a full-word load overrides the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
        end else if (cycle_load) begin
            cycle_q <= dwdata;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    // Saturating count of pushes rejected at full.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else if (drop_evt && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    // Combinational read mux so the CPU sees data in the same cycle.
    always_comb begin
        drdata = '0;
        if (region == RegionRam) begin
            drdata = ram[ram_idx];
        end else begin
            case (mmio_off)
                CONS_STATUS: drdata = status_word(occupancy, full, empty, drop_q);
                CYCLE:       drdata = cycle_q;
                default:     drdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a queue/array reference model.
module tb_dmem_responder;

    localparam int unsigned AW        = 10;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned RAM_WORDS = 1 << AW;
    localparam logic [31:0] A_TX      = 32'h8000_0000;
    localparam logic [31:0] A_STAT    = 32'h8000_0004;
    localparam logic [31:0] A_CYC     = 32'h8000_0008;

    logic        clk;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic [7:0]  cons_data;
    logic        cons_valid;
    logic        cons_ready;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [31:0] m_ram [int];
    logic [7:0]  m_fifo [$];
    int          m_drop;
    logic [31:0] m_cyc;

    dmem_responder #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .daddr      (daddr),
        .dwdata     (dwdata),
        .dwe        (dwe),
        .drdata     (drdata),
        .cons_data  (cons_data),
        .cons_valid (cons_valid),
        .cons_ready (cons_ready)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'(m_fifo.size());
        if (m_fifo.size() == DEPTH) s = s | 32'h0000_0100;
        if (m_fifo.size() == 0)     s = s | 32'h0000_0200;
        s = s | (32'(m_drop) << 16);
        return s;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        int idx;
        if (!a[31]) begin
            idx = int'((a >> 2) % RAM_WORDS);
            return m_ram.exists(idx) ? m_ram[idx] : 32'h0;
        end
        case ((a >> 2) % 8)
            1:       return exp_status();
            2:       return m_cyc;
            default: return 32'h0;
        endcase
    endfunction

    // Apply the current inputs to the model, then advance one clock edge.
    task automatic tick();
        int idx;
        logic [31:0] w;
        bit popped;
        if (reset) begin
            m_fifo.delete();
            m_drop = 0;
            m_cyc  = 32'h0;
        end else begin
            if (!daddr[31] && dwe != 4'h0) begin
                idx = int'((daddr >> 2) % RAM_WORDS);
                w = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (dwe[i]) w[8*i +: 8] = dwdata[8*i +: 8];
                m_ram[idx] = w;
            end
            popped = cons_ready && (m_fifo.size() > 0);
            if (popped) void'(m_fifo.pop_front());
            if (daddr[31] && ((daddr >> 2) % 8) == 0 && dwe[0]) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(dwdata[7:0]);
                else if (m_drop < 255) m_drop = m_drop + 1;
            end
            if (daddr[31] && ((daddr >> 2) % 8) == 2 && dwe == 4'hF) m_cyc = dwdata;
            else m_cyc = m_cyc + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        daddr  = a;
        dwdata = d;
        dwe    = we;
        tick();
        dwe    = 4'h0;
    endtask

    task automatic peek(input logic [31:0] a);
        daddr = a;
        dwe   = 4'h0;
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cons_ready = 1'b0;
        reset      = 1'b1;
        daddr      = A_TX;
        dwdata     = 32'h0000_0055;
        dwe        = 4'hF;
        tick();
        tick();
        reset = 1'b0;
        dwe   = 4'h0;
        peek(A_STAT);
        tests++;
        if (drdata !== 32'h0000_0200) begin
            fails++; $display("FAIL reset_status: got %h expected %h", drdata, 32'h200);
        end
        tests++;
        if (cons_valid !== 1'b0 || cons_data !== 8'h00) begin
            fails++; $display("FAIL reset_cons: got valid=%b data=%h expected 0/00",
                              cons_valid, cons_data);
        end
        peek(A_CYC);
        tests++;
        if (drdata !== 32'h0) begin
            fails++; $display("FAIL reset_cycle0: got %h expected 0", drdata);
        end
        tick();
        tests++;
        if (drdata !== 32'h1) begin
            fails++; $display("FAIL reset_cycle1: got %h expected 1", drdata);
        end
    endtask

    task automatic test_ram_lanes();
        write(32'h10, 32'hAABB_CCDD, 4'b1111);
        write(32'h10, 32'h0000_EE00, 4'b0010);
        peek(32'h10);
        tests++;
        if (drdata !== 32'hAABB_EEDD) begin
            fails++; $display("FAIL ram_lanes: got %h expected %h", drdata, 32'hAABB_EEDD);
        end
        peek(32'h10 + 4 * RAM_WORDS);
        tests++;
        if (drdata !== 32'hAABB_EEDD) begin
            fails++; $display("FAIL ram_alias: got %h expected %h", drdata, 32'hAABB_EEDD);
        end
        peek(32'h4000_0013);
        tests++;
        if (drdata !== 32'hAABB_EEDD) begin
            fails++; $display("FAIL ram_alias_hi: got %h expected %h", drdata, 32'hAABB_EEDD);
        end
    endtask

    task automatic test_ram_random();
        int idx [8];
        logic [31:0] a, exp;
        for (int i = 0; i < 8; i++) begin
            idx[i] = int'($urandom_range(RAM_WORDS - 1, 8));
            write(32'(idx[i]) << 2, $urandom, 4'hF);
        end
        for (int n = 0; n < 40; n++) begin
            a = ($urandom & 32'h7FFF_F003) | (32'(idx[$urandom_range(7, 0)]) << 2);
            write(a, $urandom, 4'($urandom_range(15, 1)));
        end
        // Read-during-write returns the old word.
        a = 32'(idx[0]) << 2;
        exp = exp_read(a);
        daddr = a; dwdata = ~exp; dwe = 4'hF;
        #1;
        tests++;
        if (drdata !== exp) begin
            fails++; $display("FAIL ram_rdw: got %h expected %h", drdata, exp);
        end
        tick();
        dwe = 4'h0;
        for (int i = 0; i < 8; i++) begin
            a = 32'(idx[i]) << 2;
            peek(a);
            exp = exp_read(a);
            tests++;
            if (drdata !== exp) begin
                fails++; $display("FAIL ram_random[%0d]: got %h expected %h", i, drdata, exp);
            end
        end
    endtask

    task automatic test_console_order();
        apply_reset();
        cons_ready = 1'b0;
        write(A_TX, 32'h41, 4'b0001);
        write(A_TX, 32'h42, 4'b0001);
        write(A_TX, 32'h43, 4'b0001);
        write(A_TX, 32'h44, 4'b1110);
        peek(A_STAT);
        tests++;
        if (drdata !== 32'h0000_0003) begin
            fails++; $display("FAIL cons_occ3: got %h expected %h", drdata, 32'h3);
        end
        cons_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (cons_valid !== 1'b1 || cons_data !== 8'(8'h41 + i)) begin
                fails++; $display("FAIL cons_order[%0d]: got valid=%b data=%h expected 1/%h",
                                  i, cons_valid, cons_data, 8'(8'h41 + i));
            end
            tick();
        end
        tests++;
        if (cons_valid !== 1'b0 || cons_data !== 8'h00) begin
            fails++; $display("FAIL cons_drained: got valid=%b data=%h expected 0/00",
                              cons_valid, cons_data);
        end
        cons_ready = 1'b0;
    endtask

    task automatic test_full_drop();
        logic [7:0] exp_bytes [4];
        apply_reset();
        cons_ready = 1'b0;
        for (int i = 0; i < 6; i++) write(A_TX, 32'(8'h60 + i), 4'b0001);
        peek(A_STAT);
        tests++;
        if (drdata !== 32'h0002_0104) begin
            fails++; $display("FAIL full_drop: got %h expected %h", drdata, 32'h0002_0104);
        end
        cons_ready = 1'b1;
        write(A_TX, 32'h70, 4'b0001);
        cons_ready = 1'b0;
        peek(A_STAT);
        tests++;
        if (drdata !== 32'h0002_0104 || cons_data !== 8'h61) begin
            fails++; $display("FAIL full_pushpop: got %h/%h expected %h/61",
                              drdata, cons_data, 32'h0002_0104);
        end
        exp_bytes = '{8'h61, 8'h62, 8'h63, 8'h70};
        cons_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (cons_data !== exp_bytes[i]) begin
                fails++; $display("FAIL full_drain[%0d]: got %h expected %h",
                                  i, cons_data, exp_bytes[i]);
            end
            tick();
        end
        cons_ready = 1'b0;
        peek(A_STAT);
        tests++;
        if (drdata !== 32'h0002_0200) begin
            fails++; $display("FAIL drop_persist: got %h expected %h", drdata, 32'h0002_0200);
        end
        for (int i = 0; i < 4 + 260; i++) write(A_TX, $urandom, 4'b0001);
        peek(A_STAT);
        tests++;
        if (drdata !== 32'h00FF_0104) begin
            fails++; $display("FAIL drop_sat: got %h expected %h", drdata, 32'h00FF_0104);
        end
    endtask

    task automatic test_cycle();
        write(A_CYC, 32'hFFFF_FFFE, 4'hF);
        peek(A_CYC);
        tests++;
        if (drdata !== 32'hFFFF_FFFE) begin
            fails++; $display("FAIL cyc_load: got %h expected FFFFFFFE", drdata);
        end
        tick();
        tests++;
        if (drdata !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL cyc_inc: got %h expected FFFFFFFF", drdata);
        end
        tick();
        tests++;
        if (drdata !== 32'h0) begin
            fails++; $display("FAIL cyc_wrap: got %h expected 0", drdata);
        end
        write(A_CYC, 32'h1234_5678, 4'b0011);
        peek(A_CYC);
        tests++;
        if (drdata !== 32'h1) begin
            fails++; $display("FAIL cyc_partial: got %h expected 1", drdata);
        end
        write(32'h8000_0028, 32'h0000_0100, 4'hF);
        peek(A_CYC);
        tests++;
        if (drdata !== 32'h0000_0100) begin
            fails++; $display("FAIL cyc_alias_load: got %h expected 100", drdata);
        end
    endtask

    task automatic test_mmio_misc();
        logic [31:0] a, exp;
        write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        for (int i = 0; i < 8; i++) begin
            a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFE0) | (32'(i) << 2);
            peek(a);
            exp = exp_read(a);
            tests++;
            if (drdata !== exp) begin
                fails++; $display("FAIL mmio_off[%0d]: got %h expected %h", i, drdata, exp);
            end
        end
        peek(32'h10);
        tests++;
        if (drdata !== exp_read(32'h10)) begin
            fails++; $display("FAIL mmio_no_ram: got %h expected %h", drdata, exp_read(32'h10));
        end
    endtask

    task automatic test_fifo_random();
        logic [7:0]  exp_d;
        logic [31:0] exp_s;
        apply_reset();
        for (int n = 0; n < 120; n++) begin
            cons_ready = 1'($urandom_range(1, 0));
            if ($urandom_range(2, 0) != 0) begin
                daddr  = A_TX | ($urandom & 32'h7FFF_FFE0);
                dwdata = $urandom;
                dwe    = 4'($urandom);
            end else begin
                daddr = A_STAT;
                dwe   = 4'h0;
            end
            #1;
            exp_d = (m_fifo.size() > 0) ? m_fifo[0] : 8'h00;
            tests++;
            if (cons_valid !== (m_fifo.size() > 0) || cons_data !== exp_d) begin
                fails++; $display("FAIL fifo_rand[%0d]: got valid=%b data=%h expected %b/%h",
                                  n, cons_valid, cons_data, m_fifo.size() > 0, exp_d);
            end
            tick();
            dwe = 4'h0;
            peek(A_STAT);
            exp_s = exp_status();
            tests++;
            if (drdata !== exp_s) begin
                fails++; $display("FAIL fifo_rand_stat[%0d]: got %h expected %h",
                                  n, drdata, exp_s);
            end
        end
        cons_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        cons_ready = 1'b0;
        write(A_TX, 32'h31, 4'b0001);
        write(A_TX, 32'h32, 4'b0001);
        write(A_TX, 32'h33, 4'b0001);
        cons_ready = 1'b1;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            peek(A_STAT);
            tests++;
            if (cons_valid !== 1'b0 || drdata !== 32'h0000_0200) begin
                fails++; $display("FAIL reset_drain[%0d]: got valid=%b stat=%h expected 0/200",
                                  i, cons_valid, drdata);
            end
            tick();
        end
        cons_ready = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        daddr      = 32'h0;
        dwdata     = 32'h0;
        dwe        = 4'h0;
        cons_ready = 1'b0;
        m_drop     = 0;
        m_cyc      = 32'h0;
        test_reset();
        test_ram_lanes();
        test_ram_random();
        test_console_order();
        test_full_drop();
        test_cycle();
        test_mmio_misc();
        test_fifo_random();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle CPU's `daddr`/`dwdata`/`dwe`/`drdata` port: it is the other end of the CPU's data-memory interface. It decodes each access into a word-addressed RAM with byte-lane writes or a small MMIO region. The MMIO region holds a console TX FIFO with a valid/ready drain port and a free-running cycle counter. Reads are combinational so the single-cycle CPU gets data in the same cycle; all writes and state updates occur on `posedge clk`.

## Interface
- `ADDR_WIDTH`, 10: RAM word-index width (1024 words = 4 KB).
- `FIFO_DEPTH`, 4: console FIFO entries; power of two, 2..16.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `daddr` in 32: byte address from the CPU. `daddr[31]`=0 selects RAM; 1 selects MMIO.
- `dwdata` in 32: write data, already lane-shifted by the CPU.
- `dwe` in 4: byte-lane write enables; `dwe[i]` writes `dwdata[8i+7:8i]`.
- `drdata` out 32: combinational full-word read data for `daddr`.
- `cons_data` out 8: FIFO head byte.
- `cons_valid` out 1: FIFO non-empty.
- `cons_ready` in 1: sink accepts the head byte this cycle.

## Operation
- **RAM access**
  - Word index is `daddr[ADDR_WIDTH+1:2]`. Bits `[30:ADDR_WIDTH+2]` are ignored, so RAM aliases across that range. `daddr[1:0]` is ignored.
  - Each set `dwe` bit writes its byte lane at the clock edge.
  - RAM contents are not cleared by reset.
- **MMIO map** (word offset = `daddr[4:2]`, other bits ignored)
  - `0x8000_0000` CONS_TX: a write with `dwe[0]`=1 pushes `dwdata[7:0]`. Reads return 0.
  - `0x8000_0004` CONS_STATUS, read-only:
    - `[4:0]`: occupancy.
    - `[8]`: full.
    - `[9]`: empty.
    - `[23:16]`: drop count.
    - All other bits read 0.
  - `0x8000_0008` CYCLE: reads return the counter. A write with `dwe`=4'b1111 loads `dwdata`. Partial-lane writes are ignored.
  - All other offsets read 0; writes to them are ignored.
- **FIFO**
  - Push is accepted when not full, or when full and a pop happens in the same cycle.
  - A rejected push increments the drop count, which saturates at 255.
  - Pop occurs when `cons_valid && cons_ready`.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Bytes drain in push order. Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Cycle counter**
  - Increments by 1 every cycle that `reset` is low; wraps from 0xFFFF_FFFF to 0.
  - A load takes priority over the increment: the next value is exactly `dwdata`.
- **Reset**
  - Has priority over any `dwe` in the same cycle: no RAM write, no push.
  - Clears FIFO pointers, occupancy, drop count and cycle counter.
  - Bytes already in the FIFO are discarded. A reset asserted mid-drain drops `cons_valid` after that edge.

## Timing
- Reset values:
  - `cons_valid`=0; `cons_data`=0 (head of the empty FIFO reads 0).
  - CYCLE=0; CONS_STATUS=0x0000_0200.
  - `drdata` is combinational from `daddr`: RAM or MMIO value per the map.
- Read latency is 0 cycles (combinational). Write latency is 1 edge; the value is readable in the next cycle.
- A read and write to the same RAM word in the same cycle returns the old data.
- A push in cycle N raises `cons_valid` in cycle N+1 if the FIFO was empty. `cons_valid` never depends combinationally on `dwe`.
- `cons_data` is stable while `cons_valid`=1 and `cons_ready`=0. After a pop, the next entry appears in the following cycle.
- A CYCLE read returns the registered value in the current cycle, not the incremented value.

## Structure
- **Shared package `dmem_pkg`:**
  - MMIO base (`32'h8000_0000`) and offsets `CONS_TX`=0, `CONS_STATUS`=1, `CYCLE`=2 (word offsets).
  - STATUS bit positions: `OCC_LSB`, `FULL_BIT`=8, `EMPTY_BIT`=9, `DROP_LSB`=16.
- **Sub-module `console_fifo`:**
  - Parameterised by `FIFO_DEPTH`.
  - Ports: push, push_data, pop-side valid/ready/data, occupancy, full, empty.
  - Drop counting stays in the top level.
- Top level contains the RAM array, address decode, read mux and cycle counter.

## Test plan
- **RAM byte lanes:** write 0xAABBCCDD with `dwe`=1111 at 0x10, then 0x0000_EE00 with `dwe`=0010 → a read at 0x10 returns 0xAABBEEDD. A read at 0x10 + 4·2^ADDR_WIDTH returns the same (aliasing).
- **Reset:** assert `reset` for 2 cycles with `dwe`=1111 to 0x8000_0000 → FIFO empty, CONS_STATUS reads 0x0000_0200, CYCLE reads 0 in the first cycle after deassertion and 1 in the next.
- **Console ordering:** `cons_ready`=0; push 0x41, 0x42, 0x43 → STATUS occupancy=3. Raise `cons_ready` → `cons_data` is 0x41, 0x42, 0x43 in consecutive cycles, then `cons_valid`=0.
- **Full/drop:** with `cons_ready`=0, push 6 bytes → occupancy=4, full=1, drop count=2. Push at full with `cons_ready`=1 in the same cycle → accepted, occupancy stays 4, drop count unchanged.
- **Cycle counter:** write 0xFFFF_FFFE to CYCLE with `dwe`=1111 → subsequent reads are 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000. A write with `dwe`=0011 has no effect.
- **Reset mid-drain:** FIFO holding 3 bytes with `cons_ready`=1, assert reset → `cons_valid`=0 after the reset edge. No stale bytes appear after deassertion.
